// File: rtl/spi_ifetch_pkg.sv
// Shared types and constants for the SPI instruction-fetch unit.
// Frame layout on the wire: 8-bit read command, flash byte address, 32 data bits.
package spi_ifetch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StData,
        StDone
    } state_e;

    localparam logic [7:0]  CMD_READ   = 8'h03;
    localparam logic [31:0] NOP        = 32'h00000013;
    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned DATA_BITS  = 32;
    localparam int unsigned FRAME_BITS = CMD_BITS + 24 + DATA_BITS;

    function automatic int unsigned frame_bits(input int unsigned addr_bits);
        return CMD_BITS + addr_bits + DATA_BITS;
    endfunction

    // Bytes arrive first-byte-first in the top byte of the shift register.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_shift.sv
// SPI mode-0 serialiser: SCK divider, frame bit counter, MOSI and MISO shift registers.
// One frame is started by start_i and runs until its last bit or abort_i.
module spi_shift
    import spi_ifetch_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned ADDR_BITS = 24,
    localparam int unsigned CntW     = $clog2(CMD_BITS + ADDR_BITS + DATA_BITS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic                 miso_i,
    output logic                 sck_o,
    output logic                 mosi_o,
    output logic                 bit_end_o,
    output logic [CntW-1:0]      bit_cnt_o,
    output logic [DATA_BITS-1:0] rx_o
);

    localparam int unsigned FrameBits = frame_bits(ADDR_BITS);
    localparam int unsigned TxW       = CMD_BITS + ADDR_BITS;
    localparam int unsigned Half      = CLK_DIV / 2;
    localparam int unsigned PhW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [PhW-1:0]       ph_q, ph_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 active_q, active_d;
    logic [TxW-1:0]       tx_q, tx_d;
    logic [DATA_BITS-1:0] rx_q, rx_d;
    logic                 rise;
    logic                 bit_end;

    // First high cycle of the period is where MISO is captured.
    assign rise    = active_q && (ph_q == PhW'(Half));
    assign bit_end = active_q && (ph_q == PhW'(CLK_DIV - 1));

    always_comb begin
        ph_d     = ph_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (abort_i) begin
            active_d = 1'b0;
            ph_d     = '0;
            cnt_d    = '0;
        end else if (start_i) begin
            active_d = 1'b1;
            ph_d     = '0;
            cnt_d    = '0;
            tx_d     = {CMD_READ, addr_i};
        end else if (active_q) begin
            if (rise) begin
                rx_d = {rx_q[DATA_BITS-2:0], miso_i};
            end
            if (bit_end) begin
                ph_d = '0;
                tx_d = {tx_q[TxW-2:0], 1'b0};
                if (cnt_q == CntW'(FrameBits - 1)) begin
                    active_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                ph_d = ph_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ph_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
        end else begin
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

    // MOSI only moves on a period boundary, which is always a low SCK cycle.
    assign sck_o     = active_q && (ph_q >= PhW'(Half));
    assign mosi_o    = active_q && tx_q[TxW-1];
    assign bit_end_o = bit_end;
    assign bit_cnt_o = cnt_q;
    assign rx_o      = rx_q;

endmodule

// File: rtl/spi_ifetch.sv
// Instruction fetch from SPI NOR flash: fetch handshake, pipeline stall and frame sequencing.
// Each fetch issues a READ (0x03) frame and returns one little-endian 32-bit word.
module spi_ifetch
    import spi_ifetch_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned ADDR_BITS = 24
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        fetch_req,
    input  logic        flush,
    output logic [31:0] InstrF,
    output logic        instr_valid,
    output logic        StallF,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int unsigned FrameBits = frame_bits(ADDR_BITS);
    localparam int unsigned CntW      = $clog2(FrameBits);

    state_e                 state_q, state_d;
    logic [31:0]            instr_q, instr_d;
    logic                   start;
    logic                   abort;
    logic                   bit_end;
    logic [CntW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0]   rx;
    logic [31:0]            rx_word;
    logic [ADDR_BITS-1:0]   fetch_addr;

    assign fetch_addr = {PCF[ADDR_BITS-1:2], 2'b00};

    spi_shift #(
        .CLK_DIV   (CLK_DIV),
        .ADDR_BITS (ADDR_BITS)
    ) u_shift (
        .clk_i     (CLK),
        .rst_ni    (reset),
        .start_i   (start),
        .abort_i   (abort),
        .addr_i    (fetch_addr),
        .miso_i    (spi_miso),
        .sck_o     (spi_sck),
        .mosi_o    (spi_mosi),
        .bit_end_o (bit_end),
        .bit_cnt_o (bit_cnt),
        .rx_o      (rx)
    );

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fetch_req && !flush) begin
                    start   = 1'b1;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (bit_end && bit_cnt == CntW'(CMD_BITS - 1)) begin
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (bit_end && bit_cnt == CntW'(CMD_BITS + ADDR_BITS - 1)) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end && bit_cnt == CntW'(FrameBits - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // A redirect abandons whatever is in flight, including the result cycle.
        if (flush && state_q != StIdle) begin
            state_d = StIdle;
            abort   = 1'b1;
        end
    end

    always_comb begin
        rx_word     = bswap32(rx);
        instr_valid = (state_q == StDone) && !flush;
        InstrF      = instr_valid ? rx_word : instr_q;
        instr_d     = InstrF;
        StallF      = fetch_req & ~instr_valid;
        spi_cs_n    = !((state_q == StCmd) || (state_q == StAddr) || (state_q == StData));
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q <= StIdle;
            instr_q <= NOP;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

endmodule
